// File: rtl/sobel_window_3x3_if.sv
// Pixel-in / window-out bundle between the grayscale stage, the 3x3 window
// builder and the Sobel gradient stage.
interface sobel_window_3x3_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   gray_i;
  logic                    done_i;
  logic [9*DATA_WIDTH-1:0] window_o;
  logic                    done_o;
  logic                    frame_done_o;

  // upstream/testbench side: drives pixels, observes windows
  modport master (
    output gray_i, done_i,
    input  window_o, done_o, frame_done_o
  );

  // window builder side
  modport slave (
    input  gray_i, done_i,
    output window_o, done_o, frame_done_o
  );
endinterface

// File: rtl/sobel_window_3x3.sv
// 3x3 neighbourhood builder for a raster grayscale stream. Two line buffers
// hold the previous rows; a 3x3 shift register collects column triples and
// only fully interior windows are presented, one cycle after the pixel.
module sobel_window_3x3 #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  sobel_window_3x3_if.slave bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept, col_last, row_last, interior;

  // Line buffers: lb0 = previous row, lb1 = the row before that
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  // win_q[i][j]: i = row offset (0 oldest), j = column offset (2 newest)
  logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [2:0][DATA_WIDTH-1:0]      col_tri;
  logic [9*DATA_WIDTH-1:0]         win_flat;

  logic [9*DATA_WIDTH-1:0] window_q;
  logic                    done_q, frame_done_q;

  assign accept   = bus.done_i;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  // Rows 0/1 are gated, which also hides stale line-buffer contents from a
  // previous frame or from before a reset.
  assign interior = (row >= ROW_TWO) && (col >= COL_TWO);

  // Read old buffer contents before this cycle's write lands
  assign col_tri[0] = lb1[col];
  assign col_tri[1] = lb0[col];
  assign col_tri[2] = bus.gray_i;

  // Next window: shift each row left, newest column enters on the right
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < 3; i++) begin
      win_d[i][0] = win_q[i][1];
      win_d[i][1] = win_q[i][2];
      win_d[i][2] = col_tri[i];
    end
  end

  // Pack p_ij with p00 in the MSBs and p22 in the LSBs
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win_flat[DATA_WIDTH*(8-(3*i+j)) +: DATA_WIDTH] = win_d[i][j];
  end

  // Raster position of the next pixel to arrive; wraps straight into the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line-buffer storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.gray_i;
    end
  end

  // 3x3 column shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         win_q <= '0;
    else if (accept) win_q <= win_d;
  end

  // Output window held between valid strobes, plus one-cycle valid pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q     <= '0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      done_q       <= accept && interior;
      frame_done_q <= accept && row_last && col_last;
      if (accept && interior) window_q <= win_flat;
    end
  end

  assign bus.window_o     = window_q;
  assign bus.done_o       = done_q;
  assign bus.frame_done_o = frame_done_q;
endmodule

// File: tb/tb_sobel_window_3x3.sv
// Directed bench for sobel_window_3x3: ramp frames at full and throttled
// rate, mid-frame reset and back-to-back frames.
module tb_sobel_window_3x3;
  logic clk = 1'b0;
  logic rst;

  sobel_window_3x3_if #(.DATA_WIDTH(8)) bus();

  sobel_window_3x3 #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fd_cnt = 0;
  int n_win, first_idx;
  logic [71:0] hold_w, first_w, last_w, border_w;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected window for a ramp frame (pixel = base + r*8 + c) ending at (r,c)
  function automatic logic [71:0] ramp_win(input int base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(8-(3*i+j)) +: 8] = 8'(base + (r-2+i)*8 + (c-2+j));
    return w;
  endfunction

  // One clock cycle: present a pixel (or idle), sample outputs after the edge
  task automatic step(input logic [7:0] v, input logic en);
    @(negedge clk);
    bus.gray_i = v;
    bus.done_i = en;
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
  endtask

  task automatic send_frame(input int base, input int gap, input int npix);
    n_win     = 0;
    first_idx = -1;
    for (int k = 0; k < npix; k++) begin
      int r, c;
      logic v;
      r = k / 8;
      c = k % 8;
      step(8'(base + r*8 + c), 1'b1);
      v = (r >= 2) && (c >= 2);
      chk("done_o", {71'd0, bus.done_o}, {71'd0, v});
      chk("frame_done_o", {71'd0, bus.frame_done_o}, {71'd0, k == 63});
      if (v) hold_w = ramp_win(base, r, c);
      chk("window_o", bus.window_o, hold_w);
      if (bus.done_o) begin
        n_win++;
        if (first_idx < 0) begin
          first_idx = k;
          first_w   = bus.window_o;
        end
        last_w = bus.window_o;
      end
      if (bus.frame_done_o) fd_cnt++;
      if (r == 3 && c == 2) border_w = bus.window_o;
      for (int g = 0; g < gap; g++) begin
        step(8'hA5, 1'b0);
        chk("gap_done_o", {71'd0, bus.done_o}, 72'd0);
        chk("gap_frame_done_o", {71'd0, bus.frame_done_o}, 72'd0);
        chk("gap_window_hold", bus.window_o, hold_w);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    bus.gray_i = '0;
    bus.done_i = 1'b0;
    hold_w     = '0;
    border_w   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_window_o", bus.window_o, 72'd0);
    chk("reset_done_o", {71'd0, bus.done_o}, 72'd0);
    chk("reset_frame_done_o", {71'd0, bus.frame_done_o}, 72'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate ramp frame
    send_frame(0, 0, 64);
    chk("first_idx", 72'(first_idx), 72'd18);
    chk("first_win", first_w, {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18});
    chk("win_count", 72'(n_win), 72'd36);
    chk("last_win", last_w, {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63});
    chk("border_win", border_w, {8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 8'd24, 8'd25, 8'd26});

    // Throttled ramp frame: two idle cycles after every pixel
    send_frame(0, 2, 64);
    chk("thr_win_count", 72'(n_win), 72'd36);
    chk("thr_first_win", first_w, {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18});
    chk("thr_last_win", last_w, {8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63});

    // Mid-frame reset after 20 pixels; 20th pixel left a live window on the outputs
    send_frame(0, 0, 20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_window_o", bus.window_o, 72'd0);
    chk("midrst_done_o", {71'd0, bus.done_o}, 72'd0);
    @(negedge clk);
    rst    = 1'b0;
    hold_w = '0;
    send_frame(0, 0, 64);
    chk("postrst_first_idx", 72'(first_idx), 72'd18);
    chk("postrst_first_win", first_w, {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18});

    // Back-to-back frames with no idle gap
    fd_cnt = 0;
    send_frame(0, 0, 64);
    send_frame(100, 0, 64);
    chk("b2b_first_win", first_w, {8'd100, 8'd101, 8'd102, 8'd108, 8'd109, 8'd110, 8'd116, 8'd117, 8'd118});
    chk("b2b_win_count", 72'(n_win), 72'd36);
    chk("b2b_frame_done_count", 72'(fd_cnt), 72'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
